// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped table of 2-bit saturating counters with
// tags and branch targets. Lookup from the Fetch PC is combinational; the
// table is trained from resolved conditional branches in Execute. After reset
// the table is walked one entry per cycle to clear it before predicting.
module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] PCF,
  output logic                  PredictTakenF,
  output logic [DATA_WIDTH-1:0] PredictTargetF,
  output logic                  ReadyF,
  input  logic                  UpdateEnE,
  input  logic [DATA_WIDTH-1:0] PCE,
  input  logic                  TakenE,
  input  logic [DATA_WIDTH-1:0] TargetE
);

  localparam int TAG_BITS = DATA_WIDTH - INDEX_BITS - 2;
  localparam int ENTRIES  = 1 << INDEX_BITS;

  typedef enum logic {INIT, RUN} state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] initIdx_q, initIdx_d;

  logic                  valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [ENTRIES];

  logic [INDEX_BITS-1:0] fetchIdx, execIdx;
  logic [TAG_BITS-1:0]   fetchTag, execTag;
  logic                  fetchHit, execHit;
  logic [1:0]            execCtr, ctrInc, ctrDec;

  logic                  wrEn;
  logic [INDEX_BITS-1:0] wrIdx;
  logic                  wrValid;
  logic [TAG_BITS-1:0]   wrTag;
  logic [1:0]            wrCtr;
  logic [DATA_WIDTH-1:0] wrTarget;

  // The byte-offset bits of both PCs never select anything.
  logic unusedPcBits;
  assign unusedPcBits = ^{PCF[1:0], PCE[1:0]};

  assign fetchIdx = PCF[INDEX_BITS+1:2];
  assign fetchTag = PCF[DATA_WIDTH-1:INDEX_BITS+2];
  assign execIdx  = PCE[INDEX_BITS+1:2];
  assign execTag  = PCE[DATA_WIDTH-1:INDEX_BITS+2];

  // Lookup reads the registered table directly, so a same-cycle update is
  // not bypassed and the prediction reflects pre-update contents.
  assign fetchHit       = valid_q[fetchIdx] && (tag_q[fetchIdx] == fetchTag);
  assign PredictTakenF  = ReadyF && fetchHit && ctr_q[fetchIdx][1];
  assign PredictTargetF = PredictTakenF ? target_q[fetchIdx] : PCF + DATA_WIDTH'(4);

  assign execHit = valid_q[execIdx] && (tag_q[execIdx] == execTag);
  assign execCtr = ctr_q[execIdx];
  assign ctrInc  = (execCtr == 2'b11) ? 2'b11 : execCtr + 2'd1;
  assign ctrDec  = (execCtr == 2'b00) ? 2'b00 : execCtr - 2'd1;

  // State register: reset restarts the clearing walk from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      initIdx_q <= '0;
    end else begin
      state_q   <= state_d;
      initIdx_q <= initIdx_d;
    end
  end

  // Next state: leave INIT once the last entry has been cleared.
  always_comb begin
    state_d   = state_q;
    initIdx_d = initIdx_q;
    case (state_q)
      INIT: begin
        initIdx_d = initIdx_q + 1'b1;
        if (initIdx_q == {INDEX_BITS{1'b1}}) begin
          state_d = RUN;
        end
      end
      RUN: begin
        initIdx_d = '0;
      end
      default: begin
        state_d   = INIT;
        initIdx_d = '0;
      end
    endcase
  end

  // Outputs: a single table write port shared by clearing and training.
  always_comb begin
    ReadyF   = 1'b0;
    wrEn     = 1'b0;
    wrIdx    = initIdx_q;
    wrValid  = 1'b0;
    wrTag    = '0;
    wrCtr    = 2'b01;
    wrTarget = '0;
    case (state_q)
      INIT: begin
        wrEn = 1'b1;
      end
      RUN: begin
        ReadyF = 1'b1;
        wrIdx  = execIdx;
        wrTag  = execTag;
        if (UpdateEnE) begin
          if (execHit) begin
            wrEn    = 1'b1;
            wrValid = 1'b1;
            if (TakenE) begin
              wrCtr    = ctrInc;
              wrTarget = TargetE;
            end else begin
              wrCtr    = ctrDec;
              wrTarget = target_q[execIdx];
            end
          end else if (TakenE) begin
            wrEn     = 1'b1;
            wrValid  = 1'b1;
            wrCtr    = 2'b10;
            wrTarget = TargetE;
          end
        end
      end
      default: begin
        ReadyF = 1'b0;
      end
    endcase
  end

  // Table storage: at most one entry written per cycle, none while in reset.
  always_ff @(posedge clk) begin
    if (wrEn && !rst) begin
      valid_q[wrIdx]  <= wrValid;
      tag_q[wrIdx]    <= wrTag;
      ctr_q[wrIdx]    <= wrCtr;
      target_q[wrIdx] <= wrTarget;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor with default parameters
// (32-bit PC, 64-entry table). Inputs change on the falling edge and
// outputs are sampled there, away from the rising edge.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF;
  logic        PredictTakenF;
  logic [31:0] PredictTargetF;
  logic        ReadyF;
  logic        UpdateEnE;
  logic [31:0] PCE;
  logic        TakenE;
  logic [31:0] TargetE;

  int compareCount = 0;
  int failCount    = 0;
  int initCycles;
  bit takenSeen;

  branch_predictor #(
    .DATA_WIDTH(32),
    .INDEX_BITS(6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PCF           (PCF),
    .PredictTakenF (PredictTakenF),
    .PredictTargetF(PredictTargetF),
    .ReadyF        (ReadyF),
    .UpdateEnE     (UpdateEnE),
    .PCE           (PCE),
    .TakenE        (TakenE),
    .TargetE       (TargetE)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one Execute update for a cycle, then return at the next falling edge.
  task automatic applyStimulus(input logic en, input logic [31:0] pce,
                               input logic taken, input logic [31:0] tgt);
    UpdateEnE = en;
    PCE       = pce;
    TakenE    = taken;
    TargetE   = tgt;
    @(posedge clk);
    @(negedge clk);
    UpdateEnE = 1'b0;
  endtask

  task automatic checkLookup(input string tag, input logic [31:0] pc,
                             input logic expTaken, input logic [31:0] expTarget);
    PCF = pc;
    #1;
    checkOutput({tag, ".taken"}, {31'b0, PredictTakenF}, {31'b0, expTaken});
    checkOutput({tag, ".target"}, PredictTargetF, expTarget);
  endtask

  // Count cycles with ReadyF low, starting at the current falling edge.
  task automatic measureInit();
    initCycles = 0;
    takenSeen  = 1'b0;
    while (ReadyF === 1'b0 && initCycles < 200) begin
      if (PredictTakenF !== 1'b0) takenSeen = 1'b1;
      initCycles++;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst       = 1'b1;
    PCF       = 32'h100;
    UpdateEnE = 1'b0;
    PCE       = '0;
    TakenE    = 1'b0;
    TargetE   = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetReady", {31'b0, ReadyF}, 32'd0);
    checkOutput("resetTaken", {31'b0, PredictTakenF}, 32'd0);

    // Release reset and time the clearing walk, poking an update meanwhile.
    rst       = 1'b0;
    UpdateEnE = 1'b1;
    PCE       = 32'h100;
    TakenE    = 1'b1;
    TargetE   = 32'h200;
    measureInit();
    UpdateEnE = 1'b0;
    checkOutput("initCycles", initCycles, 32'd64);
    checkOutput("initTakenSeen", {31'b0, takenSeen}, 32'd0);
    checkOutput("readyAfterInit", {31'b0, ReadyF}, 32'd1);
    checkLookup("coldLookup", 32'h100, 1'b0, 32'h104);

    // Taken allocation; same-cycle lookup still sees the cleared entry.
    PCF = 32'h100;
    UpdateEnE = 1'b1; PCE = 32'h100; TakenE = 1'b1; TargetE = 32'h200;
    #1;
    checkOutput("allocSameCycle", {31'b0, PredictTakenF}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    UpdateEnE = 1'b0;
    checkLookup("alloc", 32'h100, 1'b1, 32'h200);

    // Counter walk: 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10.
    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0);
    checkLookup("nt1", 32'h100, 1'b0, 32'h104);
    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0);
    checkLookup("nt2", 32'h100, 1'b0, 32'h104);
    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0);
    checkLookup("ntSat", 32'h100, 1'b0, 32'h104);
    applyStimulus(1'b1, 32'h100, 1'b1, 32'h200);
    checkLookup("t1", 32'h100, 1'b0, 32'h104);
    applyStimulus(1'b1, 32'h100, 1'b1, 32'h200);
    checkLookup("t2", 32'h100, 1'b1, 32'h200);
    applyStimulus(1'b1, 32'h100, 1'b1, 32'h200);
    checkLookup("t3", 32'h100, 1'b1, 32'h200);
    applyStimulus(1'b1, 32'h100, 1'b1, 32'h240);
    checkLookup("tSat", 32'h100, 1'b1, 32'h240);
    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0);
    checkLookup("ntFromSat", 32'h100, 1'b1, 32'h240);

    // Aliasing PC 0x1100 shares index 0 with 0x100 but has a different tag.
    checkLookup("aliasMiss", 32'h1100, 1'b0, 32'h1104);
    applyStimulus(1'b1, 32'h1100, 1'b0, 32'h0);
    checkLookup("aliasNtKeeps", 32'h100, 1'b1, 32'h240);
    applyStimulus(1'b0, 32'h1100, 1'b1, 32'h700);
    checkLookup("noEnableNoWrite", 32'h1100, 1'b0, 32'h1104);
    applyStimulus(1'b1, 32'h1100, 1'b1, 32'h500);
    checkLookup("aliasAlloc", 32'h1100, 1'b1, 32'h500);
    checkLookup("aliasEvicted", 32'h100, 1'b0, 32'h104);
    applyStimulus(1'b1, 32'h1100, 1'b0, 32'h0);
    checkLookup("aliasWeak", 32'h1100, 1'b0, 32'h1104);

    // Same-cycle lookup and taken allocation at 0x140 (index 16).
    PCF = 32'h140;
    UpdateEnE = 1'b1; PCE = 32'h140; TakenE = 1'b1; TargetE = 32'h600;
    #1;
    checkOutput("bypassTaken", {31'b0, PredictTakenF}, 32'd0);
    checkOutput("bypassTarget", PredictTargetF, 32'h144);
    @(posedge clk);
    @(negedge clk);
    UpdateEnE = 1'b0;
    checkLookup("afterBypass", 32'h140, 1'b1, 32'h600);

    // Byte-offset bits are ignored by the lookup.
    checkLookup("offsetIgnored", 32'h143, 1'b1, 32'h600);

    // One-cycle reset in RUN wipes everything that was trained.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    PCF = 32'h140;
    measureInit();
    checkOutput("reinitCycles", initCycles, 32'd64);
    checkOutput("reinitTakenSeen", {31'b0, takenSeen}, 32'd0);
    checkLookup("wiped140", 32'h140, 1'b0, 32'h144);
    checkLookup("wiped1100", 32'h1100, 1'b0, 32'h1104);
    checkLookup("wiped100", 32'h100, 1'b0, 32'h104);

    // Reset in the middle of clearing restarts the full walk.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    measureInit();
    checkOutput("midInitRestart", initCycles, 32'd64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
